alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle accumulator ALU: a parametrised successor to the single-cycle ALU. The accumulator is held internally instead of being fed back by the caller. Adds signed iterative multiply, divide and modulo, a start/busy/done handshake, synchronous reset and status flags. It sits between the sequencer and the register file: the sequencer issues one command per handshake and reads `acc_out` when `done` is asserted.

## Interface
- `DATA_WIDTH`, 16: operand, accumulator and result width W, with W ≥ 4.
- `clock`  in  1  system clock; rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  clock enable; low freezes all state.
- `start`  in  1  command request.
- `cmd`  in  4  opcode, sampled at accept.
- `opperand`  in  W  signed operand B, sampled at accept.
- `acc_out`  out  W  signed accumulator value.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle pulse: result and flags are valid.
- `zero`, `neg`, `carry`, `ovf`, `dz`  out  1 each  status flags.

## Operation
- **Opcodes.** A = accumulator, B = `opperand`.
  - 0 NOP
  - 1 ADD: A+B
  - 2 SUB: A−B
  - 3 MUL: A·B, low W bits
  - 4 DIV: A/B, truncates toward zero
  - 5 MOD: remainder, takes the sign of A
  - 6 LOAD: B
  - 7 CLR: 0
  - 8 AND
  - 9 OR
  - A XOR
  - B NAND
  - C NOT: ~A, B ignored
  - D–F reserved, treated as NOP
- **Accept.** A command is accepted on a rising edge where `reset`=0, `enable`=1, `start`=1 and `busy`=0. `start` while busy is ignored; nothing is queued.
- **States.**
  - IDLE → EXEC on accept of MUL, or of DIV/MOD with B≠0.
  - All other accepts stay in IDLE.
  - EXEC → FIX when the iteration counter reaches W−1.
  - FIX → IDLE.
- **MUL.** Shift-add on magnitudes, one bit per EXEC cycle. FIX applies the sign (XOR of operand signs) and truncates to W bits.
- **DIV/MOD.** Restoring division on magnitudes, one quotient bit per EXEC cycle. FIX applies sign correction.
- **Flags.** All flags update only when `done` is set.
  - `zero`: result == 0.
  - `neg`: result MSB.
  - `carry`:
    - ADD: unsigned carry-out.
    - SUB: unsigned borrow.
    - MUL: full signed 2W-bit product does not fit in W bits.
    - All other opcodes: 0.
  - `ovf`:
    - ADD/SUB: signed overflow.
    - MUL: equal to `carry`.
    - DIV with A = −2^(W−1) and B = −1: quotient wraps to −2^(W−1) and `ovf`=1.
    - All other opcodes: 0.
  - `dz`: set on DIV/MOD with B=0. Accumulator is unchanged; `zero`/`neg` reflect the unchanged A; `carry`/`ovf` = 0.
  - NOP and reserved opcodes: `done` still pulses, A is unchanged, and all flags recompute with `carry`=`ovf`=`dz`=0.

## Timing
- **Reset.** Values from the reset edge, regardless of state, including mid-EXEC/FIX:
  - `acc_out`=0, `busy`=0, `done`=0
  - `zero`=1, `neg`=`carry`=`ovf`=`dz`=0
  - FSM in IDLE, iteration counter 0
- **Single-cycle ops.** NOP, ADD, SUB, LOAD, CLR, logic ops, and DIV/MOD with B=0. Let t0 be the accept edge.
  - `acc_out` and flags update at t0.
  - `done`=1 for the cycle after t0.
  - `busy` stays 0.
- **MUL/DIV/MOD.**
  - `busy` rises at t0 and stays high through W EXEC cycles plus 1 FIX cycle.
  - At edge t0+W+1: `acc_out` and flags update, `busy` falls, `done`=1 for one cycle.
  - Latency from accept to `done` is W+1 cycles; for W=16 that is 17.
- **Between results.** `acc_out` holds its previous value during EXEC/FIX; intermediate values are never visible.
- **Back-to-back issue.** The earliest next accept is the edge where `done` is high. Back-to-back single-cycle ops give one result per cycle.
- **`enable`=0.** No state change: counter, FSM, `acc_out`, `busy`, `done` and flags all hold, so a `done` pulse stretches until the next enabled edge. `reset` overrides `enable`.
- **Operand sampling.** `cmd` and `opperand` are sampled only at accept. They may change freely while busy.

## Test plan
All scenarios use W=16.
1. **Reset and simple arithmetic.** Assert reset → all outputs at their reset values. LOAD 50, then ADD 32 → `acc_out`=82 with `done` 1 cycle after accept. SUB 5 → 77.
2. **MUL.** From 77, MUL 9 → `busy` high for 17 cycles, `acc_out`=693 at `done`, `carry`=`ovf`=0. Then LOAD 300, MUL 300 → `acc_out`=0x5F90, `carry`=`ovf`=1.
3. **Signed DIV and MOD.**
   - From 693, DIV −7 → −99 (0xFF9D), `neg`=1.
   - LOAD −100, MOD 7 → −2.
   - LOAD 0x8000, DIV −1 → 0x8000, `ovf`=1.
4. **Divide by zero.** LOAD 42, DIV 0 → `done` after 1 cycle, `acc_out`=42, `dz`=1, `busy` never asserted.
5. **Handshake.** During a MUL, pulse `start` with ADD 1 → ignored, MUL result unchanged. Drop `enable` for 5 cycles mid-MUL → `done` arrives 5 cycles late (22 cycles after accept) with the correct value.
6. **Logic and reset abort.**
   - LOAD 0x003C, AND 0x00CA → 0x0008.
   - NOT → 0xFFF7.
   - Start MUL, assert `reset` at cycle 8 → next cycle `busy`=0, `acc_out`=0, no `done` pulse.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: signed accumulator ALU with iterative MUL/DIV/MOD,
// start/busy/done handshake, clock enable and status flags.
module alu_mc #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic [3:0]            cmd,
  input  logic [DATA_WIDTH-1:0] opperand,
  output logic [DATA_WIDTH-1:0] acc_out,
  output logic                  busy,
  output logic                  done,
  output logic                  zero,
  output logic                  neg,
  output logic                  carry,
  output logic                  ovf,
  output logic                  dz
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_DIV  = 4'h4;
  localparam logic [3:0] OP_MOD  = 4'h5;
  localparam logic [3:0] OP_LOAD = 4'h6;
  localparam logic [3:0] OP_CLR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NAND = 4'hB;
  localparam logic [3:0] OP_NOT  = 4'hC;

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic           op_mul;
  logic           op_mod;
  logic           sgn_a;
  logic           sgn_b;
  logic           div_wrap;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] prod;
  logic [W-1:0]   mplier;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [W-1:0]   dvs;

  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [W:0]     dshift;
  logic [W:0]     dtrial;
  logic [W-1:0]   sc_res;
  logic           sc_c;
  logic           sc_v;
  logic           sc_dz;
  logic           multi;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quo_s;
  logic [W-1:0]   rem_s;
  logic [W-1:0]   fx_res;
  logic           mul_big;
  logic           accept;

  assign busy   = state != S_IDLE;
  assign accept = start && !busy;
  assign a_mag  = acc_out[W-1] ? -acc_out : acc_out;
  assign b_mag  = opperand[W-1] ? -opperand : opperand;
  assign sum    = {1'b0, acc_out} + {1'b0, opperand};
  assign diff   = {1'b0, acc_out} - {1'b0, opperand};

  always_comb begin
    sc_res = acc_out;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_dz  = 1'b0;
    multi  = 1'b0;
    unique case (1'b1)
      cmd == OP_ADD: begin
        sc_res = sum[W-1:0];
        sc_c   = sum[W];
        sc_v   = (acc_out[W-1] == opperand[W-1]) &&
                 (sum[W-1] != acc_out[W-1]);
      end
      cmd == OP_SUB: begin
        sc_res = diff[W-1:0];
        sc_c   = diff[W];
        sc_v   = (acc_out[W-1] != opperand[W-1]) &&
                 (diff[W-1] != acc_out[W-1]);
      end
      cmd == OP_MUL: multi = 1'b1;
      cmd == OP_DIV, cmd == OP_MOD: begin
        sc_dz = opperand == '0;
        multi = opperand != '0;
      end
      cmd == OP_LOAD: sc_res = opperand;
      cmd == OP_CLR:  sc_res = '0;
      cmd == OP_AND:  sc_res = acc_out & opperand;
      cmd == OP_OR:   sc_res = acc_out | opperand;
      cmd == OP_XOR:  sc_res = acc_out ^ opperand;
      cmd == OP_NAND: sc_res = ~(acc_out & opperand);
      cmd == OP_NOT:  sc_res = ~acc_out;
      default: ;
    endcase
  end

  // restoring division step: borrow out means restore
  assign dshift  = {rem, quo[W-1]};
  assign dtrial  = dshift - {1'b0, dvs};
  assign prod_s  = (sgn_a ^ sgn_b) ? -prod : prod;
  assign mul_big = prod_s[2*W-1:W-1] != {(W+1){prod_s[W-1]}};
  assign quo_s   = (sgn_a ^ sgn_b) ? -quo : quo;
  assign rem_s   = sgn_a ? -rem : rem;
  assign fx_res  = op_mul ? prod_s[W-1:0] :
                   op_mod ? rem_s : quo_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc_out  <= '0;
      done     <= 1'b0;
      zero     <= 1'b1;
      neg      <= 1'b0;
      carry    <= 1'b0;
      ovf      <= 1'b0;
      dz       <= 1'b0;
      op_mul   <= 1'b0;
      op_mod   <= 1'b0;
      sgn_a    <= 1'b0;
      sgn_b    <= 1'b0;
      div_wrap <= 1'b0;
      mcand    <= '0;
      prod     <= '0;
      mplier   <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
    end else if (enable) begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && multi) begin
            state    <= S_EXEC;
            cnt      <= '0;
            op_mul   <= cmd == OP_MUL;
            op_mod   <= cmd == OP_MOD;
            sgn_a    <= acc_out[W-1];
            sgn_b    <= opperand[W-1];
            div_wrap <= (cmd == OP_DIV) && (acc_out == SMIN) &&
                        (opperand == '1);
            mcand    <= {{W{1'b0}}, a_mag};
            mplier   <= b_mag;
            prod     <= '0;
            quo      <= a_mag;
            rem      <= '0;
            dvs      <= b_mag;
          end else if (accept) begin
            acc_out <= sc_res;
            zero    <= sc_res == '0;
            neg     <= sc_res[W-1];
            carry   <= sc_c;
            ovf     <= sc_v;
            dz      <= sc_dz;
            done    <= 1'b1;
          end
        end
        S_EXEC: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (dtrial[W]) begin
            rem <= dshift[W-1:0];
            quo <= {quo[W-2:0], 1'b0};
          end else begin
            rem <= dtrial[W-1:0];
            quo <= {quo[W-2:0], 1'b1};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_FIX;
            cnt   <= '0;
          end
        end
        S_FIX: begin
          acc_out <= fx_res;
          zero    <= fx_res == '0;
          neg     <= fx_res[W-1];
          carry   <= op_mul && mul_big;
          ovf     <= (op_mul && mul_big) || div_wrap;
          dz      <= 1'b0;
          done    <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc with an
// arithmetic reference model and a decoupled monitor.
module tb_alu_mc;
  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   cmd = 4'h0;
  logic [W-1:0] opperand = '0;
  logic [W-1:0] acc_out;
  logic         busy;
  logic         done;
  logic         zero;
  logic         neg;
  logic         carry;
  logic         ovf;
  logic         dz;

  alu_mc #(.DATA_WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .start(start),
    .cmd(cmd),
    .opperand(opperand),
    .acc_out(acc_out),
    .busy(busy),
    .done(done),
    .zero(zero),
    .neg(neg),
    .carry(carry),
    .ovf(ovf),
    .dz(dz)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] acc;
    logic z, n, c, v, d;
    int t0;
    int lat;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic en_q = 1'b0;
  logic [W-1:0] macc = '0;

  always @(posedge clock) begin
    cyc  <= cyc + 1;
    en_q <= enable;
  end

  function automatic void model(input logic [3:0] c,
                                input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                output exp_t e,
                                output bit multi);
    longint sa, sb, ua, ub, t, lo, hi;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    lo = -(longint'(1) << (W - 1));
    hi = (longint'(1) << (W - 1)) - 1;
    e.acc = a; e.c = 0; e.v = 0; e.d = 0;
    e.t0 = 0; e.lat = 0;
    multi = 0;
    case (c)
      4'h1: begin
        t = sa + sb; e.acc = t[W-1:0];
        e.c = ((ua + ub) >> W) != 0;
        e.v = (t < lo) || (t > hi);
      end
      4'h2: begin
        t = sa - sb; e.acc = t[W-1:0];
        e.c = ua < ub;
        e.v = (t < lo) || (t > hi);
      end
      4'h3: begin
        t = sa * sb; e.acc = t[W-1:0];
        e.c = (t < lo) || (t > hi);
        e.v = e.c; multi = 1;
      end
      4'h4: begin
        if (sb == 0) e.d = 1;
        else begin
          multi = 1;
          if (sa == lo && sb == -1) e.v = 1;
          else begin t = sa / sb; e.acc = t[W-1:0]; end
        end
      end
      4'h5: begin
        if (sb == 0) e.d = 1;
        else begin multi = 1; t = sa % sb; e.acc = t[W-1:0]; end
      end
      4'h6: e.acc = b;
      4'h7: e.acc = '0;
      4'h8: e.acc = a & b;
      4'h9: e.acc = a | b;
      4'hA: e.acc = a ^ b;
      4'hB: e.acc = ~(a & b);
      4'hC: e.acc = ~a;
      default: ;
    endcase
    e.z = e.acc == '0;
    e.n = e.acc[W-1];
  endfunction

  task automatic issue(input logic [3:0] c, input logic [W-1:0] b,
                       input int extra, input bit push);
    exp_t e;
    bit m;
    int g = 0;
    while (busy && g < 100) begin @(negedge clock); g++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL issue_wait busy=%b want 0", busy);
    end
    start = 1'b1; cmd = c; opperand = b;
    model(c, macc, b, e, m);
    e.t0 = cyc + 1;
    e.lat = (m ? W + 1 : 0) + extra;
    if (push) begin q.push_back(e); macc = e.acc; end
    @(negedge clock);
    start = 1'b0;
    cmd = 4'($urandom);
    opperand = W'($urandom);
  endtask

  task automatic expect_acc(input string nm, input logic [W-1:0] v);
    int g = 0;
    while (!done && g < 60) begin @(negedge clock); g++; end
    checks++;
    if (!done || acc_out !== v) begin
      errors++;
      $display("FAIL %s acc=%h done=%b want acc=%h", nm, acc_out, done, v);
    end
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (done && en_q) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done acc=%h", acc_out);
        end else begin
          e = q.pop_front();
          if ({acc_out, zero, neg, carry, ovf, dz} !==
              {e.acc, e.z, e.n, e.c, e.v, e.d}) begin
            errors++;
            $display("FAIL result acc=%h znvcd=%b%b%b%b%b want acc=%h znvcd=%b%b%b%b%b",
                     acc_out, zero, neg, carry, ovf, dz,
                     e.acc, e.z, e.n, e.c, e.v, e.d);
          end
          checks++;
          if (cyc - e.t0 != e.lat) begin
            errors++;
            $display("FAIL latency got=%0d want=%0d", cyc - e.t0, e.lat);
          end
        end
      end
    end
  end

  logic [W-1:0] sp [5] = '{16'h0000, 16'hFFFF, 16'h8000,
                           16'h0001, 16'h7FFF};

  initial begin : stim
    int g;
    logic [3:0] c;
    logic [W-1:0] b;
    repeat (3) @(negedge clock);
    chk("rst_acc", acc_out, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_zero", W'(zero), W'(1));
    chk("rst_flags", W'({neg, carry, ovf, dz}), '0);
    reset = 1'b0;
    @(negedge clock);

    issue(4'h6, 16'd50, 0, 1);
    issue(4'h1, 16'd32, 0, 1);
    expect_acc("add", 16'd82);
    issue(4'h2, 16'd5, 0, 1);
    expect_acc("sub", 16'd77);

    issue(4'h3, 16'd9, 0, 1);
    chk("mul_busy", W'(busy), W'(1));
    expect_acc("mul", 16'd693);
    issue(4'h6, 16'd300, 0, 1);
    issue(4'h3, 16'd300, 0, 1);
    expect_acc("mul_big", 16'h5F90);
    chk("mul_big_cv", W'({carry, ovf}), W'(3));

    issue(4'h6, 16'd693, 0, 1);
    issue(4'h4, -16'sd7, 0, 1);
    expect_acc("div_neg", 16'hFF9D);
    issue(4'h6, -16'sd100, 0, 1);
    issue(4'h5, 16'd7, 0, 1);
    expect_acc("mod_neg", 16'hFFFE);
    issue(4'h6, 16'h8000, 0, 1);
    issue(4'h4, 16'hFFFF, 0, 1);
    expect_acc("div_wrap", 16'h8000);
    chk("div_wrap_ovf", W'(ovf), W'(1));

    issue(4'h6, 16'd42, 0, 1);
    issue(4'h4, 16'd0, 0, 1);
    chk("dz_busy", W'(busy), '0);
    expect_acc("dz_acc", 16'd42);
    chk("dz_flag", W'(dz), W'(1));

    issue(4'h3, 16'd3, 0, 1);
    repeat (4) @(negedge clock);
    start = 1'b1; cmd = 4'h1; opperand = 16'd1;
    @(negedge clock);
    start = 1'b0;
    expect_acc("mul_ignore", 16'd126);

    issue(4'h3, 16'd2, 5, 1);
    repeat (5) @(negedge clock);
    enable = 1'b0;
    repeat (5) @(negedge clock);
    enable = 1'b1;
    expect_acc("mul_stall", 16'd252);

    issue(4'h6, 16'h003C, 0, 1);
    issue(4'h8, 16'h00CA, 0, 1);
    expect_acc("and", 16'h0008);
    issue(4'hC, 16'h1234, 0, 1);
    expect_acc("not", 16'hFFF7);

    issue(4'h3, 16'd5, 0, 0);
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_busy", W'(busy), '0);
    chk("abort_acc", acc_out, '0);
    chk("abort_done", W'(done), '0);
    reset = 1'b0;
    macc = '0;
    repeat (20) @(negedge clock);

    for (int i = 0; i < 250; i++) begin
      c = 4'($urandom_range(0, 15));
      b = W'($urandom);
      if ($urandom_range(0, 3) == 0) b = sp[$urandom_range(0, 4)];
      issue(c, b, 0, 1);
      if ($urandom_range(0, 7) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clock);
    end

    g = 0;
    while (q.size() != 0 && g < 200) begin @(negedge clock); g++; end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
